// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundles the two byte requesters and the tx_uart-facing
//                outputs of the transmit arbiter.
//                  req0/data0/ack0 : requester 0 (result/echo path)
//                  req1/data1/ack1 : requester 1 (status/diagnostic source)
//                  tx_ready/tx_data: start strobe and byte towards tx_uart
//                  busy/owner      : arbiter status
//                The master modport is the requester side. The slave modport
//                is the arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       busy;
    logic       owner;

    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1, tx_ready, tx_data, busy, owner
    );

    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1, tx_ready, tx_data, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that shares one tx_uart between two byte
//                requesters. Each grant produces one start strobe and one ack.
//                The grant is then held for a full frame plus guard time
//                before re-arbitration.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-low reset
//                bus  - uart_tx_arbiter_if.slave (requests, acks, tx side,
//                       busy/owner status)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FRAME_BITS = 10,
    parameter int GUARD_CYC  = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int C_BIT_CYC   = CLK_FREQ / BAUD;
    localparam int C_FRAME_CYC = C_BIT_CYC * FRAME_BITS;
    localparam int C_HOLD_CYC  = C_FRAME_CYC + GUARD_CYC;
    localparam int C_CNT_W     = $clog2(C_HOLD_CYC) + 1;
    // START and the WAIT cycle that sees zero are both part of the hold.
    // The load value therefore excludes them.
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(C_HOLD_CYC - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_next_cnt;
    logic                 r_owner;
    logic                 w_next_owner;
    logic [7:0]           r_tx_data;
    logic [7:0]           w_next_tx_data;
    logic                 r_busy;
    logic                 w_next_busy;
    logic                 w_winner;

    // Requester 1 wins if it is alone, or on a tie when 0 was served last.
    // owner resets to 1, so requester 0 wins the first tie.
    assign w_winner = bus.req1 & (~bus.req0 | ~r_owner);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_owner   <= 1'b1;
            r_tx_data <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_owner   <= w_next_owner;
            r_tx_data <= w_next_tx_data;
            r_busy    <= w_next_busy;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_owner   = r_owner;
        w_next_tx_data = r_tx_data;
        w_next_busy    = r_busy;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_next_owner   = w_winner;
                    w_next_tx_data = w_winner ? bus.data1 : bus.data0;
                    w_next_busy    = 1'b1;
                    w_next_state   = S_START;
                end
            end
            S_START: begin
                w_next_cnt   = C_CNT_LOAD;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_busy  = 1'b0;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The strobe and the ack are decoded from the registered state. Both
    // therefore last exactly the single START cycle. Only one ack can fire.
    assign bus.tx_ready = (r_state == S_START);
    assign bus.ack0     = (r_state == S_START) & ~r_owner;
    assign bus.ack1     = (r_state == S_START) &  r_owner;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter.
//                The bench uses BAUD=5_000_000, so FRAME_CYC=100 and the hold
//                is 102 cycles.
//                A time-based reference model predicts every output on every
//                cycle. Table vectors and directed sequences cover the
//                multi-cycle corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int BAUD       = 5_000_000;
    localparam int FRAME_BITS = 10;
    localparam int GUARD_CYC  = 2;
    localparam int FRAME_CYC  = (CLK_FREQ / BAUD) * FRAME_BITS;
    localparam int HOLD       = FRAME_CYC + GUARD_CYC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FRAME_BITS(FRAME_BITS),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requesters: byte queues, new data on ack -------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always @(posedge clk) begin
        #1;
        if (bus.ack0 && q0.size() > 0) void'(q0.pop_front());
        if (bus.ack1 && q1.size() > 0) void'(q1.pop_front());
        bus.req0 = (q0.size() > 0);
        bus.req1 = (q1.size() > 0);
        if (q0.size() > 0) bus.data0 = q0[0];
        if (q1.size() > 0) bus.data1 = q1[0];
    end

    initial begin
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
    end

    // ---------------- reference model and per-cycle checker ----------------
    // Model in time: a grant issued in cycle t_start occupies the line for
    // HOLD cycles. Arbitration happens in any cycle at or after t_start+HOLD.
    int         t_start = -1000;
    logic       m_owner = 1'b1;
    logic [7:0] m_data  = 8'h00;
    int         ev_cyc[$];
    logic [7:0] ev_data[$];
    logic       ev_port[$];
    int         busy_run      = 0;
    int         last_busy_len = 0;

    always @(negedge clk) begin
        logic e_rdy;
        if (!rst) begin
            t_start = -1000;
            m_owner = 1'b1;
            m_data  = 8'h00;
        end
        e_rdy = (cyc == t_start);
        chk("tx_ready", bus.tx_ready, e_rdy);
        chk("ack0", bus.ack0, e_rdy && !m_owner);
        chk("ack1", bus.ack1, e_rdy && m_owner);
        chk("busy", bus.busy, (cyc >= t_start) && (cyc < t_start + HOLD));
        chk("tx_data", bus.tx_data, m_data);
        chk("owner", bus.owner, m_owner);
        if (bus.tx_ready === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_data.push_back(bus.tx_data);
            ev_port.push_back(bus.owner);
        end
        if (bus.busy === 1'b1) busy_run++;
        else begin
            if (busy_run > 0) last_busy_len = busy_run;
            busy_run = 0;
        end
        if (rst && cyc >= t_start + HOLD && (bus.req0 || bus.req1)) begin
            m_owner = (bus.req0 && bus.req1) ? !m_owner : bus.req1;
            m_data  = m_owner ? bus.data1 : bus.data0;
            t_start = cyc + 1;
        end
        cyc++;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic apply_reset();
        q0.delete();
        q1.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack0"}, bus.ack0, 1'b0);
        chk({tag, "_ack1"}, bus.ack1, 1'b0);
        chk({tag, "_tx_ready"}, bus.tx_ready, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_tx_data"}, bus.tx_data, 8'h00);
        chk({tag, "_owner"}, bus.owner, 1'b1);
    endtask

    task automatic wait_ev(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (ev_cyc.size() < n && b > 0) begin
            @(negedge clk); #1;
            b--;
        end
        checks++;
        if (ev_cyc.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d strobes expected %0d", tag, ev_cyc.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        while ((bus.busy !== 1'b0 || q0.size() > 0 || q1.size() > 0) && b > 0) begin
            @(negedge clk); #1;
            b--;
        end
        checks++;
        if (b == 0) begin
            errors++;
            $display("FAIL idle_timeout: got busy=%0b expected 0", bus.busy);
        end
    endtask

    typedef struct {
        bit         r0;
        bit         r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_port;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        int n0;
        logic [7:0] exp_seq[8];
        logic [7:0] exp_seq_init[8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};

        vecs[0] = '{1'b1, 1'b0, 8'h73, 8'h00, 1'b0, 8'h73};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h5C, 1'b1, 8'h5C};
        vecs[2] = '{1'b1, 1'b1, 8'h03, 8'hA5, 1'b0, 8'h03};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00};
        exp_seq = exp_seq_init;

        // 1. reset, then 200 quiet cycles
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("rst");
        @(posedge clk); #2 rst = 1'b1;
        repeat (200) @(posedge clk);
        #2;
        chk("quiet_strobes", ev_cyc.size(), 0);
        check_reset_outputs("quiet");

        // 2. table vectors, each starting from reset
        foreach (vecs[i]) begin
            apply_reset();
            base = ev_cyc.size();
            n0   = cyc;
            if (vecs[i].r0) q0.push_back(vecs[i].d0);
            if (vecs[i].r1) q1.push_back(vecs[i].d1);
            wait_ev(base + 1, 20, "vec");
            if (ev_cyc.size() > base) begin
                chk("vec_latency", ev_cyc[base] - n0, 2);
                chk("vec_port", ev_port[base], vecs[i].exp_port);
                chk("vec_data", ev_data[base], vecs[i].exp_data);
            end
            if (vecs[i].r0 && vecs[i].r1) begin
                wait_ev(base + 2, HOLD + 20, "vec2");
                if (ev_cyc.size() > base + 1) begin
                    chk("vec2_port", ev_port[base + 1], 1'b1);
                    chk("vec2_data", ev_data[base + 1], vecs[i].d1);
                    chk("vec2_spacing", ev_cyc[base + 1] - ev_cyc[base], HOLD + 1);
                end
            end
            wait_idle(3 * HOLD);
            repeat (3) @(posedge clk);
            if (i == 0) begin
                chk("busy_len", last_busy_len, HOLD);
                chk("no_second_strobe", ev_cyc.size(), base + 1);
            end
        end

        // 3. contention fairness: two streams of four bytes
        apply_reset();
        base = ev_cyc.size();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(8'h10 + 8'(k));
            q1.push_back(8'h20 + 8'(k));
        end
        wait_ev(base + 8, 8 * (HOLD + 2) + 20, "stream");
        if (ev_cyc.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("stream_data", ev_data[base + k], exp_seq[k]);
                if (k > 0) chk("stream_spacing", ev_cyc[base + k] - ev_cyc[base + k - 1], HOLD + 1);
            end
        end
        wait_idle(3 * HOLD);

        // 4. late request from requester 1 during a requester 0 frame
        apply_reset();
        base = ev_cyc.size();
        q0.push_back(8'h4C);
        wait_ev(base + 1, 20, "late0");
        repeat (30) @(posedge clk);
        #2 q1.push_back(8'h6E);
        wait_ev(base + 2, HOLD + 20, "late1");
        if (ev_cyc.size() >= base + 2) begin
            chk("late_port", ev_port[base + 1], 1'b1);
            chk("late_data", ev_data[base + 1], 8'h6E);
            chk("late_spacing", ev_cyc[base + 1] - ev_cyc[base], HOLD + 1);
        end
        wait_idle(3 * HOLD);

        // 5. reset 50 cycles into the wait phase, requester 0 still pending
        apply_reset();
        base = ev_cyc.size();
        q0.push_back(8'h41);
        q0.push_back(8'h42);
        wait_ev(base + 1, 20, "mid0");
        repeat (51) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_tx_data", bus.tx_data, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        n0 = cyc;
        wait_ev(base + 2, 10, "mid1");
        if (ev_cyc.size() >= base + 2) begin
            chk("mid_regrant_port", ev_port[base + 1], 1'b0);
            chk("mid_regrant_data", ev_data[base + 1], 8'h42);
            chk("mid_regrant_latency", ev_cyc[base + 1] - n0 <= 2, 1'b1);
        end
        wait_idle(3 * HOLD);

        // 6. random traffic checked cycle by cycle against the model
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            if ($urandom_range(7) == 0 && q0.size() < 3) q0.push_back(8'($urandom));
            if ($urandom_range(7) == 0 && q1.size() < 3) q1.push_back(8'($urandom));
            if (k == 1500) begin
                rst = 1'b0;
                @(posedge clk); #2 rst = 1'b1;
            end
        end
        wait_idle(10 * HOLD);
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
